// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format select, opcodes, result entry.
// Entry fields are sized for the widest XLEN; narrower builds use the low bits.
package imm_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZIMM  = 3'd7
    } imm_src_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] target;
        logic                misalign;
    } imm_entry_t;

    // Only branch and jump targets are subject to the alignment trap.
    function automatic logic is_ctrl_xfer(imm_src_e src);
        return (src == IMM_B) || (src == IMM_J);
    endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Input/output handshake bundle of imm_gen_stage; master drives instructions and out_ready.
interface imm_gen_stage_if #(parameter int XLEN = 32);
    import imm_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    imm_src_e        imm_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_target;
    logic            out_misalign;

    modport master (
        output in_valid, instr, pc, imm_src, out_ready,
        input  in_ready, out_valid, out_imm, out_pc, out_target, out_misalign
    );

    modport slave (
        input  in_valid, instr, pc, imm_src, out_ready,
        output in_ready, out_valid, out_imm, out_pc, out_target, out_misalign
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction for every RV32I/RV64I format plus shamt and CSR zimm.
// Zero latency; no handshake.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_src_e        imm_src,
    output logic [XLEN-1:0] imm
);

    logic [31:0] raw;

    // Every format is first built as a 32-bit value already sign- or zero-extended,
    // so one signed widening covers both XLEN choices.
    always_comb begin
        raw = '0;
        case (imm_src)
            IMM_NONE:  raw = '0;
            IMM_I:     raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     raw = {instr[31:12], 12'b0};
            IMM_J:     raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: raw = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            IMM_ZIMM:  raw = {27'b0, instr[19:15]};
            default:   raw = '0;
        endcase
    end

    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with PC-relative target; 1-cycle latency when empty.
// SKID=1: main+skid entries, in_ready registered; SKID=0: single entry, in_ready = !out_valid || out_ready.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_stage_if.slave io
);

    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] sum;
    imm_entry_t      new_dat;
    imm_entry_t      main_dat;
    imm_entry_t      skid_dat;
    logic            main_vld;
    logic            skid_vld;
    logic            main_free;
    logic            in_xfer;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (io.instr),
        .imm_src (io.imm_src),
        .imm     (dec_imm)
    );

    assign sum = io.pc + dec_imm;

    always_comb begin
        new_dat          = '0;
        new_dat.imm      = XLEN_MAX'(dec_imm);
        new_dat.pc       = XLEN_MAX'(io.pc);
        new_dat.target   = XLEN_MAX'(sum);
        new_dat.misalign = is_ctrl_xfer(io.imm_src) && sum[1];
    end

    assign main_free   = !main_vld || io.out_ready;
    assign io.in_ready = SKID ? !skid_vld : main_free;
    assign in_xfer     = io.in_valid && io.in_ready;

    // While skid is occupied in_ready is low, so a freed main refills from skid only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (main_free) begin
            if (skid_vld) begin
                main_dat <= skid_dat;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= in_xfer;
                if (in_xfer) begin
                    main_dat <= new_dat;
                end
            end
        end else if (SKID && in_xfer) begin
            skid_dat <= new_dat;
            skid_vld <= 1'b1;
        end
    end

    assign io.out_valid    = main_vld;
    assign io.out_imm      = main_dat.imm[XLEN-1:0];
    assign io.out_pc       = main_dat.pc[XLEN-1:0];
    assign io.out_target   = main_dat.target[XLEN-1:0];
    assign io.out_misalign = main_dat.misalign;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Drives XLEN=32 and XLEN=64 instances with identical traffic; scoreboards check each output stream.
module tb_imm_gen_stage;
    import imm_pkg::*;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] pc;
        logic [63:0] tgt;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic bp_rand;
    logic bp_val;
    int   checks = 0;
    int   errors = 0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32)) io32 ();
    imm_gen_stage_if #(.XLEN(64)) io64 ();

    imm_gen_stage #(.XLEN(32), .SKID(1'b1)) u_dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .io(io32));
    imm_gen_stage #(.XLEN(64), .SKID(1'b1)) u_dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .io(io64));

    function automatic exp_t model(input logic [31:0] ins, input logic [2:0] src,
                                   input logic [63:0] pcv, input int xlen);
        exp_t        e;
        longint      v;
        logic [63:0] mask;
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        case (src)
            3'd1:    v = longint'($signed(ins[31:20]));
            3'd2:    v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd3:    v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd4:    v = longint'($signed({ins[31:12], 12'h000}));
            3'd5:    v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd6:    v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd7:    v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        e.imm = 64'(v) & mask;
        e.pc  = pcv & mask;
        e.tgt = (e.pc + e.imm) & mask;
        e.mis = ((src == 3'd3) || (src == 3'd5)) && e.tgt[1];
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a rising edge; returns at the rising edge where the entry was accepted.
    task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [63:0] pcv);
        int   n;
        logic rdy;
        n = 0;
        #1;
        io32.in_valid = 1'b1;   io64.in_valid = 1'b1;
        io32.instr    = ins;    io64.instr    = ins;
        io32.imm_src  = imm_src_e'(src);
        io64.imm_src  = imm_src_e'(src);
        io32.pc       = pcv[31:0];
        io64.pc       = pcv;
        forever begin
            rdy = io32.in_ready;
            @(posedge clk);
            if (rdy) begin
                q32.push_back(model(ins, src, pcv, 32));
                q64.push_back(model(ins, src, pcv, 64));
                break;
            end
            n++;
            if (n > 200) begin
                check("send_timeout", 64'(n), 64'd0);
                break;
            end
            #1;
        end
    endtask

    task automatic idle(input int n);
        #1;
        io32.in_valid = 1'b0;
        io64.in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        io32.out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : bp_val;
        io64.out_ready = io32.out_ready;
    end

    // Scoreboard plus hold-stability check for the 32-bit instance.
    logic held32;
    exp_t prev32;
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = '{imm: 64'(io32.out_imm), pc: 64'(io32.out_pc), tgt: 64'(io32.out_target), mis: io32.out_misalign};
        if (rst_n && held32) begin
            check("hold32_valid", 64'(io32.out_valid), 64'd1);
            check("hold32_data", cur.imm ^ cur.tgt ^ {cur.pc[62:0], cur.mis}, prev32.imm ^ prev32.tgt ^ {prev32.pc[62:0], prev32.mis});
        end
        held32 = rst_n && io32.out_valid && !io32.out_ready && !flush;
        prev32 = cur;
        if (rst_n && io32.out_valid && io32.out_ready && !flush) begin
            if (q32.size() == 0) begin
                check("sb32_unexpected", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                check("sb32_imm", cur.imm, e.imm);
                check("sb32_pc", cur.pc, e.pc);
                check("sb32_target", cur.tgt, e.tgt);
                check("sb32_misalign", 64'(cur.mis), 64'(e.mis));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && io64.out_valid && io64.out_ready && !flush) begin
            if (q64.size() == 0) begin
                check("sb64_unexpected", 64'd1, 64'd0);
            end else begin
                e = q64.pop_front();
                check("sb64_imm", io64.out_imm, e.imm);
                check("sb64_pc", io64.out_pc, e.pc);
                check("sb64_target", io64.out_target, e.tgt);
                check("sb64_misalign", 64'(io64.out_misalign), 64'(e.mis));
            end
        end
    end

    initial begin
        exp_t ea, eb, ec;
        int   n;
        rst_n = 1'b0; flush = 1'b0; bp_rand = 1'b0; bp_val = 1'b1;
        held32 = 1'b0;
        io32.in_valid = 1'b0; io64.in_valid = 1'b0;
        io32.instr = '0; io64.instr = '0; io32.pc = '0; io64.pc = '0;
        io32.imm_src = IMM_NONE; io64.imm_src = IMM_NONE;
        io32.out_ready = 1'b1; io64.out_ready = 1'b1;
        #1;
        check("rst_out_valid", 64'(io32.out_valid), 64'd0);
        check("rst_in_ready", 64'(io32.in_ready), 64'd1);
        check("rst_out_imm", 64'(io32.out_imm), 64'd0);
        check("rst_out_target", io64.out_target, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Directed decode points.
        send(32'hFFF00093, 3'd1, 64'h0); idle(0);
        @(negedge clk);
        check("i_valid", 64'(io32.out_valid), 64'd1);
        check("i_imm", 64'(io32.out_imm), 64'hFFFF_FFFF);
        check("i_target", 64'(io32.out_target), 64'hFFFF_FFFF);
        @(posedge clk);
        send(32'hFE209EE3, 3'd3, 64'h100); idle(0);
        @(negedge clk);
        check("b_imm", 64'(io32.out_imm), 64'hFFFF_FFFC);
        check("b_target", 64'(io32.out_target), 64'h0000_00FC);
        check("b_misalign", 64'(io32.out_misalign), 64'd0);
        @(posedge clk);
        send(32'h800000B7, 3'd4, 64'h0); idle(0);
        @(negedge clk);
        check("u64_imm", io64.out_imm, 64'hFFFF_FFFF_8000_0000);
        @(posedge clk);
        send(32'h03F09093, 3'd6, 64'h0); idle(0);
        @(negedge clk);
        check("shamt64_imm", io64.out_imm, 64'h3F);
        check("shamt32_imm", 64'(io32.out_imm), 64'h1F);
        @(posedge clk);

        // Backpressure: A and B held, C stalled, then all three drain back to back.
        ea = model(32'h00100093, 3'd1, 64'h10, 32);
        eb = model(32'h00200093, 3'd1, 64'h20, 32);
        ec = model(32'h00300093, 3'd1, 64'h30, 32);
        bp_val = 1'b0;
        send(32'h00100093, 3'd1, 64'h10);
        send(32'h00200093, 3'd1, 64'h20);
        fork
            begin
                send(32'h00300093, 3'd1, 64'h30);
                idle(0);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 64'(io32.in_ready), 64'd0);
                    check("bp_hold_a", 64'(io32.out_imm), ea.imm);
                end
                @(posedge clk);
                bp_val = 1'b1;
                @(negedge clk);
                check("drain_a", {63'(io32.out_valid), 1'b0} | 64'(io32.out_pc), {63'd1, 1'b0} | ea.pc);
                @(negedge clk);
                check("drain_b", {63'(io32.out_valid), 1'b0} | 64'(io32.out_pc), {63'd1, 1'b0} | eb.pc);
                @(negedge clk);
                check("drain_c", {63'(io32.out_valid), 1'b0} | 64'(io32.out_pc), {63'd1, 1'b0} | ec.pc);
            end
        join
        @(posedge clk);
        idle(2);

        // Flush with both entries full and a new entry presented.
        bp_val = 1'b0;
        send(32'h00500093, 3'd1, 64'h50);
        send(32'h00600093, 3'd1, 64'h60);
        #1;
        flush = 1'b1;
        io32.instr = 32'h00700093; io64.instr = 32'h00700093;
        @(posedge clk);
        #1;
        flush = 1'b0;
        io32.in_valid = 1'b0; io64.in_valid = 1'b0;
        q32.delete(); q64.delete();
        bp_val = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 64'(io32.out_valid), 64'd0);
        check("flush_in_ready", 64'(io32.in_ready), 64'd1);
        check("flush_out_valid64", 64'(io64.out_valid), 64'd0);
        @(negedge clk);
        check("flush_no_emit", 64'(io32.out_valid), 64'd0);
        @(posedge clk);

        // Asynchronous reset while entries are held.
        bp_val = 1'b0;
        send(32'h00800093, 3'd1, 64'h80);
        send(32'h00900093, 3'd1, 64'h90);
        idle(0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(io32.out_valid), 64'd0);
        check("arst_in_ready", 64'(io32.in_ready), 64'd1);
        check("arst_out_imm", 64'(io32.out_imm), 64'd0);
        check("arst_out_pc", io64.out_pc, 64'd0);
        check("arst_misalign", 64'(io32.out_misalign), 64'd0);
        q32.delete(); q64.delete();
        bp_val = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        send(32'hFFF00093, 3'd1, 64'h4); idle(0);
        @(negedge clk);
        check("post_rst_valid", 64'(io32.out_valid), 64'd1);
        check("post_rst_target", 64'(io32.out_target), 64'h3);
        @(posedge clk);

        // Random traffic under random backpressure.
        bp_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(0);
        bp_rand = 1'b0;
        bp_val  = 1'b1;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_q32", 64'(q32.size()), 64'd0);
        check("drain_q64", 64'(q64.size()), 64'd0);
        check("final_idle", 64'(io32.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
